// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the ECP5 EHXPLLL pixel-clock PLL: pulses PLL RST, filters the
// asynchronous LOCK, retries a PLL that will not lock, latches a sticky fault
// after repeated failures and holds the downstream pipeline in reset until the
// output clock has been stable for LOCK_FILTER_CYCLES.
// Build option: define PLL_SUP_RELOCK_RESET_EN to re-pulse pll_rst after a lock
// loss in RUN; by default a lock loss only re-enters WAIT_LOCK.
// All logic runs on the free-running board clock (clkin).
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 2500000,
    parameter int LOCK_FILTER_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t          state_q;
    logic            pll_rst_q;
    logic            sys_rst_q;
    logic            ready_q;
    logic            fault_q;
    logic [2:0]      retry_q;
    logic [7:0]      loss_q;
    logic [PW-1:0]   pulse_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [FW-1:0]   flt_cnt_q;
    logic            lk_meta_q;
    logic            lk_sync_q;

    logic            lk;
    logic            pulse_done;
    logic            tmo_hit;
    logic            flt_done;
    logic            retry_max;
    logic [7:0]      loss_d;

    // Lock counter saturates so a flapping PLL never wraps back to a small count.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL LOCK output (data path, no reset).
    always_ff @(posedge clkin) begin
        lk_meta_q <= pll_locked;
        lk_sync_q <= lk_meta_q;
    end

    assign lk         = lk_sync_q;
    assign pulse_done = (pulse_cnt_q == PW'(PLL_RST_CYCLES - 1));
    assign tmo_hit    = (tmo_cnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1));
    assign flt_done   = lk && (flt_cnt_q == FW'(LOCK_FILTER_CYCLES - 1));
    assign retry_max  = (retry_q == 3'(MAX_RETRIES));
    assign loss_d     = sat_inc8(loss_q);

    // Supervisor FSM with registered outputs; rst overrides every state.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= ST_RESET;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            flt_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (pulse_done) begin
                        state_q   <= ST_WAIT_LOCK;
                        pll_rst_q <= 1'b0;
                        tmo_cnt_q <= '0;
                        flt_cnt_q <= '0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + PW'(1);
                    end
                end
                ST_WAIT_LOCK, ST_FILTER: begin
                    if (state_q == ST_FILTER && flt_done) begin
                        // Filter completion beats a coincident timeout.
                        state_q   <= ST_RUN;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                        retry_q   <= '0;
                    end else if (tmo_hit) begin
                        if (retry_max) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RESET;
                            retry_q     <= retry_q + 3'd1;
                            pulse_cnt_q <= '0;
                        end
                        pll_rst_q <= 1'b1;
                    end else begin
                        // Timeout keeps counting across FILTER->WAIT_LOCK bounces.
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        if (state_q == ST_WAIT_LOCK) begin
                            if (lk) begin
                                state_q   <= ST_FILTER;
                                flt_cnt_q <= '0;
                            end
                        end else if (lk) begin
                            flt_cnt_q <= flt_cnt_q + FW'(1);
                        end else begin
                            state_q   <= ST_WAIT_LOCK;
                            flt_cnt_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lk) begin
                        loss_q    <= loss_d;
                        sys_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
`ifdef PLL_SUP_RELOCK_RESET_EN
                        state_q     <= ST_RESET;
                        pll_rst_q   <= 1'b1;
                        pulse_cnt_q <= '0;
`else
                        state_q   <= ST_WAIT_LOCK;
                        tmo_cnt_q <= '0;
                        flt_cnt_q <= '0;
`endif
                    end
                end
                ST_FAULT: begin
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    fault_q   <= 1'b1;
                end
                default: begin
                    state_q     <= ST_RESET;
                    pll_rst_q   <= 1'b1;
                    sys_rst_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    pulse_cnt_q <= '0;
                end
            endcase
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst         = sys_rst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule
